// File: rtl/mod_step_counter_if.sv
// Control/status bundle for mod_step_counter.
// The master drives the controls; the slave (counter) drives the status.
interface mod_step_counter_if #(
  parameter int WIDTH = 5
);
  logic             clr;
  logic             load;
  logic             enab;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             wrap;
  logic             zero;
  logic             err;

  modport master (
    output clr, load, enab, up, sat, step, cnt_in,
    input  cnt_out, wrap, zero, err
  );

  modport slave (
    input  clr, load, enab, up, sat, step, cnt_in,
    output cnt_out, wrap, zero, err
  );
endinterface

// File: rtl/mod_step_counter.sv
// Up/down modulo counter with programmable step, load, clear and flags.
// Optional saturation: define MOD_STEP_COUNTER_SAT_EN.
module mod_step_counter #(
  parameter int WIDTH  = 5,
  parameter int MODULO = 32
) (
  input logic                clk,
  input logic                rst,
  mod_step_counter_if.slave  bus
);

  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("mod_step_counter: MODULO out of range 2..2^WIDTH");
  end

  localparam logic [WIDTH:0]   MD   = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  logic             err_q;

  logic [WIDTH-1:0] cnt_nx;
  logic             wrap_nx;
  logic             err_nx;

  // One extra bit keeps cnt+step and cnt+MODULO from overflowing.
  logic [WIDTH:0] cur;
  logic [WIDTH:0] stp;
  logic [WIDTH:0] ld;
  logic [WIDTH:0] sum;
  logic           step_bad;
  logic           load_bad;
  logic           up_ovf;
  logic           dn_ovf;

  assign cur      = {1'b0, cnt_q};
  assign stp      = {1'b0, bus.step};
  assign ld       = {1'b0, bus.cnt_in};
  assign sum      = cur + stp;
  assign step_bad = stp >= MD;
  assign load_bad = ld >= MD;
  assign up_ovf   = sum >= MD;
  assign dn_ovf   = stp > cur;

  // Count result for an enabled cycle with a legal step.
  logic [WIDTH-1:0] cnt_cnt;
  logic             wrap_cnt;

  always_comb begin
    cnt_cnt  = cnt_q;
    wrap_cnt = 1'b0;
    if (bus.up) begin
      if (up_ovf) begin
`ifdef MOD_STEP_COUNTER_SAT_EN
        if (bus.sat) begin
          cnt_cnt  = TOP;
          wrap_cnt = cnt_q != TOP;
        end else begin
          cnt_cnt  = WIDTH'(sum - MD);
          wrap_cnt = 1'b1;
        end
`else
        cnt_cnt  = WIDTH'(sum - MD);
        wrap_cnt = 1'b1;
`endif
      end else begin
        cnt_cnt = WIDTH'(sum);
      end
    end else begin
      if (dn_ovf) begin
`ifdef MOD_STEP_COUNTER_SAT_EN
        if (bus.sat) begin
          cnt_cnt  = '0;
          wrap_cnt = cnt_q != '0;
        end else begin
          cnt_cnt  = WIDTH'(cur + MD - stp);
          wrap_cnt = 1'b1;
        end
`else
        cnt_cnt  = WIDTH'(cur + MD - stp);
        wrap_cnt = 1'b1;
`endif
      end else begin
        cnt_cnt = WIDTH'(cur - stp);
      end
    end
  end

  always_comb begin
    cnt_nx  = cnt_q;
    wrap_nx = 1'b0;
    err_nx  = err_q;
    if (bus.clr) begin
      cnt_nx = '0;
      err_nx = 1'b0;
    end else if (bus.load) begin
      if (load_bad) begin
        cnt_nx = TOP;
        err_nx = 1'b1;
      end else begin
        cnt_nx = bus.cnt_in;
      end
    end else if (bus.enab) begin
      if (step_bad) begin
        err_nx = 1'b1;
      end else begin
        cnt_nx  = cnt_cnt;
        wrap_nx = wrap_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_nx;
      wrap_q <= wrap_nx;
      err_q  <= err_nx;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.wrap    = wrap_q;
  assign bus.err     = err_q;
  assign bus.zero    = cnt_q == '0;

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench for mod_step_counter, WIDTH=5 MODULO=20.
// Expected responses are queued by the driver and checked by a monitor.
module tb_mod_step_counter;

  localparam int W = 5;
  localparam int M = 20;

  typedef struct {
    string tag;
    int    cnt;
    int    wrap;
    int    err;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_vec;
  int   n_bad;

  mod_step_counter_if #(.WIDTH(W)) bus ();

  mod_step_counter #(.WIDTH(W), .MODULO(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int ec, input int ew, input int ee);
    int gc, gw, ge, gz, ez;
    gc = int'(bus.cnt_out);
    gw = int'(bus.wrap);
    ge = int'(bus.err);
    gz = int'(bus.zero);
    ez = (ec == 0) ? 1 : 0;
    n_vec++;
    if (gc != ec || gw != ew || ge != ee || gz != ez) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d wrap=%0d err=%0d zero=%0d want cnt=%0d wrap=%0d err=%0d zero=%0d",
               tag, gc, gw, ge, gz, ec, ew, ee, ez);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, e.cnt, e.wrap, e.err);
    end
  end

  task automatic apply(input string tag, input logic c, input logic l,
                       input logic e, input logic u, input logic s,
                       input int st, input int ci,
                       input int ec, input int ew, input int ee);
    exp_t x;
    bus.clr    = c;
    bus.load   = l;
    bus.enab   = e;
    bus.up     = u;
    bus.sat    = s;
    bus.step   = W'(st);
    bus.cnt_in = W'(ci);
    @(posedge clk);
    #1;
    x.tag  = tag;
    x.cnt  = ec;
    x.wrap = ew;
    x.err  = ee;
    q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.clr = 0; bus.load = 0; bus.enab = 0; bus.up = 1;
    bus.sat = 0; bus.step = '0; bus.cnt_in = '0;
    #3;
    chk("reset_init", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // err set, then count at 7, then async reset mid-cycle
    apply("load_bad_pre", 0, 1, 0, 1, 0, 0, 25, 19, 0, 1);
    apply("load7",        0, 1, 0, 1, 0, 0, 7,  7,  0, 1);
    #2 rst = 1'b0;
    #1 chk("async_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      apply("idle_after_rst", 0, 0, 0, 1, 0, 3, 5, 0, 0, 0);

    apply("load18",   0, 1, 0, 1, 0, 0, 18, 18, 0, 0);
    apply("up_wrap",  0, 0, 1, 1, 0, 3, 0,  1,  1, 0);
    apply("up_nowrap",0, 0, 1, 1, 0, 3, 0,  4,  0, 0);

    apply("load2",    0, 1, 0, 0, 0, 0, 2,  2,  0, 0);
    apply("dn_wrap",  0, 0, 1, 0, 0, 5, 0,  17, 1, 0);
    apply("step0",    0, 0, 1, 0, 0, 0, 0,  17, 0, 0);

    apply("load25",   0, 1, 0, 1, 0, 0, 25, 19, 0, 1);
    apply("step20",   0, 0, 1, 1, 0, 20, 0, 19, 0, 1);
    apply("clr",      1, 0, 0, 1, 0, 0, 0,  0,  0, 0);

    apply("clr_prio", 1, 1, 1, 1, 0, 1, 9,  0,  0, 0);
    apply("load_prio",0, 1, 1, 1, 0, 1, 9,  9,  0, 0);

    apply("load15",   0, 1, 0, 1, 0, 0, 15, 15, 0, 0);
    apply("b2b_wrap1",0, 0, 1, 1, 0, 10, 0, 5,  1, 0);
    apply("b2b_wrap2",0, 0, 1, 1, 0, 15, 0, 0,  1, 0);
    apply("dn_from0", 0, 0, 1, 0, 0, 1, 0,  19, 1, 0);
    apply("dn_max",   0, 0, 1, 0, 0, 19, 0, 0,  0, 0);
    apply("up_max",   0, 0, 1, 1, 0, 19, 0, 19, 0, 0);
    apply("idle",     0, 0, 0, 1, 0, 19, 0, 19, 0, 0);

    apply("load17",   0, 1, 0, 1, 1, 0, 17, 17, 0, 0);
`ifdef MOD_STEP_COUNTER_SAT_EN
    apply("sat_up",   0, 0, 1, 1, 1, 5, 0,  19, 1, 0);
    apply("sat_up2",  0, 0, 1, 1, 1, 5, 0,  19, 0, 0);
    apply("load3",    0, 1, 0, 0, 1, 0, 3,  3,  0, 0);
    apply("sat_dn",   0, 0, 1, 0, 1, 4, 0,  0,  1, 0);
    apply("sat_dn2",  0, 0, 1, 0, 1, 4, 0,  0,  0, 0);
`else
    apply("sat_up",   0, 0, 1, 1, 1, 5, 0,  2,  1, 0);
    apply("sat_up2",  0, 0, 1, 1, 1, 5, 0,  7,  0, 0);
    apply("load3",    0, 1, 0, 0, 1, 0, 3,  3,  0, 0);
    apply("sat_dn",   0, 0, 1, 0, 1, 4, 0,  19, 1, 0);
    apply("sat_dn2",  0, 0, 1, 0, 1, 4, 0,  15, 0, 0);
`endif

    bus.enab = 0;
    bus.load = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_step_counter.md
# mod_step_counter

Parametrised, registered up/down modulo counter with programmable step, parallel load, synchronous clear and wrap/terminal-count flags. It is the next-generation counter for the VeriRisc datapath and its sequencers (program counter, phase and loop counters). It extends the basic load/enable counter with direction, arbitrary modulus, step size, status outputs and optional saturation.

## Interface
- WIDTH, 5, counter width in bits.
- MODULO, 32, count range 0..MODULO-1.
  - Legal range 2..2^WIDTH.
  - Illegal values stop elaboration via a generate-time check.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  parallel load of cnt_in.
- enab  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  saturate instead of wrap (see Configuration).
- step  input  WIDTH  increment/decrement amount; 0 means hold.
- cnt_in  input  WIDTH  load value.
- cnt_out  output  WIDTH  current count.
- wrap  output  1  one-cycle pulse: the last update crossed the modulo boundary.
- zero  output  1  cnt_out == 0, decoded from the register with no added latency.
- err  output  1  sticky error: illegal step or load value seen.

## Operation
- Priority: rst > clr > load > enab.
- rst low, at any time: cnt_out=0, wrap=0, err=0, taking effect immediately without a clock.
- clr: cnt_out=0, wrap=0, err=0.
- load:
  - cnt_in < MODULO: cnt_out=cnt_in.
  - Otherwise: cnt_out=MODULO-1 and err set.
  - wrap=0 in both cases.
- enab with load=0:
  - Arithmetic is done at WIDTH+1 bits to avoid intermediate overflow.
  - step >= MODULO: cnt_out holds, err set, wrap=0.
  - Up: s = cnt_out + step.
    - s >= MODULO: cnt_out = s - MODULO, wrap=1.
    - Otherwise: cnt_out = s.
  - Down:
    - step > cnt_out: cnt_out = cnt_out + MODULO - step, wrap=1.
    - Otherwise: cnt_out = cnt_out - step.
  - step=0: cnt_out holds, wrap=0.
- Idle (no clr, load or enab): cnt_out holds, wrap=0.
- err is sticky. Only rst or clr clears it.
- cnt_out never leaves 0..MODULO-1 after reset.

## Timing
- All outputs are registered, except zero, which decodes the cnt_out register.
- Latency is one clock from a sampled control to the updated cnt_out, wrap and err.
- wrap is high for exactly the one cycle following the wrapping edge. Back-to-back wraps hold it high on consecutive cycles.
- Simultaneous clr+load+enab: only clr takes effect.
- load+enab: load wins and no count occurs that cycle.
- rst asserted mid-count: outputs go to 0 asynchronously.
- rst release: must be synchronous to clk externally. The first update occurs on the first rising edge with rst high.

## Configuration
- Macro: MOD_STEP_COUNTER_SAT_EN.
- Defined, with sat=1:
  - Up where s >= MODULO: cnt_out = MODULO-1.
  - Down where step > cnt_out: cnt_out = 0.
  - wrap=1 in the cycle the clamp first engages, i.e. when the count changes into the limit by clamping.
  - Stays 0 while pinned at the limit.
- Defined, with sat=0: wrap behaviour exactly as in Operation.
- Not defined:
  - The sat port remains in the interface but is ignored.
  - The counter always wraps, and no saturation logic is synthesised.

## Test plan
- Reset: rst low mid-count at cnt_out=7 -> cnt_out=0, wrap=0 and err=0 before the next edge. Release, then hold idle 3 cycles -> cnt_out stays 0 and zero=1.
- Up wrap, WIDTH=5, MODULO=20: load 18, then enab up=1 step=3 -> cnt_out=1 and wrap=1 for one cycle. The next step=3 -> cnt_out=4, wrap=0.
- Down wrap, MODULO=20: load 2, then enab up=0 step=5 -> cnt_out=17, wrap=1. Then step=0 -> cnt_out holds at 17.
- Errors, MODULO=20: load cnt_in=25 -> cnt_out=19 and err=1. Then enab step=20 -> cnt_out holds at 19 and err stays 1. Then clr -> cnt_out=0, err=0.
- Priority: clr=load=enab=1 with cnt_in=9 -> cnt_out=0. Then load=enab=1, cnt_in=9, step=1 -> cnt_out=9.
- With MOD_STEP_COUNTER_SAT_EN defined, MODULO=20, sat=1:
  - At 17, up step=5 -> cnt_out=19, wrap=1; a repeat -> 19, wrap=0.
  - At 3, down step=4 -> cnt_out=0.
  - Without the macro, the same stimulus from 17 -> cnt_out=2.
